// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing a single-port data RAM between the core (port 0) and a second
// requester (port 1); one command outstanding at a time, read latency absorbed internally.
module ram_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIXED_PRIO   = 0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] address_ram_o,
    output logic [DATA_W-1:0] data_ram_o,
    output logic              wren_ram_o,
    input  logic [DATA_W-1:0] q_ram_i
);

    typedef enum logic [1:0] {StIdle, StCmd, StRwait} state_e;

    localparam logic [2:0] CntLoad = 3'(READ_LATENCY - 1);

    state_e            state_q;
    logic              last_q;
    logic              port_q;
    logic              cmd_we_q;
    logic [2:0]        cnt_q;
    logic              gnt0_q, gnt1_q;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] data_q;
    logic              wren_q;
    logic              win1_d;

    // last_q == 1 means port 1 won most recently, so port 0 takes the next tie.
    always_comb begin
        win1_d = 1'b0;
        if (FIXED_PRIO != 0) begin
            win1_d = req1_i && !req0_i;
        end else begin
            win1_d = req1_i && (!req0_i || !last_q);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            port_q    <= 1'b0;
            cmd_we_q  <= 1'b0;
            cnt_q     <= 3'd0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req0_i || req1_i) begin
                        address_q <= win1_d ? addr1_i : addr0_i;
                        data_q    <= win1_d ? wdata1_i : wdata0_i;
                        wren_q    <= win1_d ? we1_i : we0_i;
                        cmd_we_q  <= win1_d ? we1_i : we0_i;
                        gnt0_q    <= !win1_d;
                        gnt1_q    <= win1_d;
                        port_q    <= win1_d;
                        last_q    <= win1_d;
                        state_q   <= StCmd;
                    end
                end
                StCmd: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    wren_q <= 1'b0;
                    if (cmd_we_q) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= CntLoad;
                        state_q <= StRwait;
                    end
                end
                StRwait: begin
                    if (cnt_q == 3'd0) begin
                        if (port_q) begin
                            rdata1_q  <= q_ram_i;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= q_ram_i;
                            rvalid0_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt0_o        = gnt0_q;
    assign gnt1_o        = gnt1_q;
    assign rvalid0_o     = rvalid0_q;
    assign rvalid1_o     = rvalid1_q;
    assign rdata0_o      = rdata0_q;
    assign rdata1_o      = rdata1_q;
    assign busy_o        = (state_q != StIdle);
    assign address_ram_o = address_q;
    assign data_ram_o    = data_q;
    assign wren_ram_o    = wren_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port data RAM between the stack-machine core (port 0) and a second requester such as a program loader or debug monitor (port 1). It serialises read and write commands onto the RAM `address_ram`/`data_ram`/`wren_ram`/`q_ram` bus. It absorbs the RAM's fixed read latency and returns read data with a one-cycle valid pulse. Arbitration is round-robin or fixed-priority, selected by parameter.

## Interface
- `DATA_W`, 16, RAM data width.
- `ADDR_W`, 16, RAM address width.
- `READ_LATENCY`, 2, cycles from the first cycle `address_ram` carries a read address to the cycle `q_ram` is valid; legal range 1–7.
- `FIXED_PRIO`, 0, 0 = round-robin; 1 = port 0 always wins ties.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0`/`req1` in 1: command request; held with its command fields until the matching grant.
- `we0`/`we1` in 1: 1 = write, 0 = read.
- `addr0`/`addr1` in ADDR_W: command address.
- `wdata0`/`wdata1` in DATA_W: write data.
- `gnt0`/`gnt1` out 1: one-cycle pulse; the command is on the RAM bus this cycle.
- `rvalid0`/`rvalid1` out 1: one-cycle pulse; `rdata` is valid this cycle.
- `rdata0`/`rdata1` out DATA_W: read data; holds its value until the next read completes for that port.
- `busy` out 1: high when the arbiter is not in IDLE.
- `address_ram` out ADDR_W, `data_ram` out DATA_W, `wren_ram` out 1: RAM command, all registered.
- `q_ram` in DATA_W: RAM read data.

## Operation
- States:
  - IDLE: accepts a command.
  - CMD: command on the bus for 1 cycle.
  - RWAIT: waits for read data, with a down-counter.
- IDLE, edge with any `req` high:
  - Select the winner.
  - Register the winner's `addr`/`wdata` into `address_ram`/`data_ram`.
  - Set `wren_ram` to the winner's `we`.
  - Set the winner's `gnt` = 1.
  - Record the winner and `we`.
  - Go to CMD.
- IDLE, no request: outputs hold, `wren_ram` stays 0.
- CMD, next edge:
  - `wren_ram` ← 0 and `gnt` ← 0.
  - Write: go to IDLE.
  - Read: load the counter with READ_LATENCY−1 and go to RWAIT.
- RWAIT: decrement each edge. At the edge where the counter is 0:
  - Capture `q_ram` into the recorded port's `rdata`.
  - Pulse that port's `rvalid` in the following cycle.
  - Go to IDLE.
- `address_ram` and `data_ram` hold their last value outside CMD. `wren_ram` is high only in CMD for writes.
- Round-robin: a `last` pointer records the most recent winner. On a tie, the port ≠ `last` wins; `last` updates on every grant. With FIXED_PRIO=1, port 0 wins every tie and `last` is ignored.
- A single request always wins, regardless of mode.
- Requesters may change `req` and the command fields at the edge that ends their `gnt` cycle. The arbiter never samples requests in CMD or RWAIT, so a grant is never duplicated.
- Only one command is outstanding at a time. A request arriving during CMD or RWAIT waits.
- Asynchronous reset, also valid mid-command or mid-read:
  - State → IDLE; any pending read is discarded and produces no `rvalid`.
  - `last` → port 1, so port 0 wins the first tie.
  - Counter → 0.

## Timing
- Reset values: `gnt0`, `gnt1`, `rvalid0`, `rvalid1`, `busy`, `wren_ram` = 0; `address_ram`, `data_ram`, `rdata0`, `rdata1` = 0.
- Accept at edge E0. CMD is the cycle E0–E1, with `gnt` and the bus command visible.
- Write:
  - RAM captures at E1.
  - IDLE from E1; next accept at E2.
  - Write throughput: 1 command per 2 cycles.
- Read:
  - `q_ram` is valid in the cycle ending at E(READ_LATENCY+1); `rdata` is captured at that edge.
  - `rvalid` is high in the cycle after the capture edge.
  - IDLE from E(READ_LATENCY+1); next accept at E(READ_LATENCY+2).
  - With L=2: gnt in cycle 1, rvalid in cycle 4.
- `busy` is high during CMD and RWAIT. It is low in the cycle carrying `rvalid`.
- No combinational path exists from a `req`/`addr` input to any output.

## Test plan
- Reset mid-read:
  - Stimulus: port 1 read issued; assert `reset` one cycle after `gnt1`; release; then port 0 reads.
  - Required: no `rvalid1` ever; all outputs zero during reset; port 0 is granted at the first edge after reset is released.
- Single write then read:
  - Stimulus: port 0 writes 0x1234 to address 0x0005; then port 0 reads address 0x0005.
  - Required: `wren_ram` high for exactly 1 cycle with address 0x0005 and data 0x1234. The read gives `gnt0` in cycle 1, `rvalid0` in cycle 4 (L=2), `rdata0` = 0x1234.
- Round-robin tie:
  - Stimulus: `req0` and `req1` held continuously, both writing.
  - Required: grants alternate 0,1,0,1, 2 cycles apart; first grant goes to port 0.
- Fixed priority:
  - Stimulus: FIXED_PRIO=1, both requests held for 3 commands each.
  - Required: port 0 gets 3 grants; only then does port 1 get a grant.
- Request during busy:
  - Stimulus: port 1 raises `req1` one cycle after port 0's read grant.
  - Required: `gnt1` only at E(READ_LATENCY+2); port 0's `rdata` is unaffected.
- Latency sweep:
  - Stimulus: READ_LATENCY = 1, 2, 4 against a RAM model with matching latency.
  - Required: `rvalid` in cycle L+2 after accept, with correct data each time.
